// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// fixed 34-cycle latency. Divider present only when MULDIV_DIV_EN is defined.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] RY,
    input  logic [WIDTH-1:0] BUSin,
    input  logic             MUL,
    input  logic             DIV,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ZHIGH,
    output logic [WIDTH-1:0] ZLOW,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_fix_ph;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_zhigh;
    logic [WIDTH-1:0] r_zlow;
    logic             w_start;
    logic             w_can_start;
    logic [WIDTH:0]   w_booth_a;

`ifdef MULDIV_DIV_EN
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] w_ry_abs;
    logic [WIDTH-1:0] w_bus_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;

    assign w_start   = MUL | DIV;
    assign w_ry_abs  = RY[WIDTH-1] ? -RY : RY;
    assign w_bus_abs = BUSin[WIDTH-1] ? -BUSin : BUSin;
    assign w_rem_sh  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial   = w_rem_sh - r_m;
    assign div_zero  = r_div_zero;
`else
    logic w_unused_div;
    assign w_start      = MUL;
    assign div_zero     = 1'b0;
    assign w_unused_div = DIV;
`endif

    assign busy  = r_busy;
    assign done  = r_done;
    assign ZHIGH = r_zhigh;
    assign ZLOW  = r_zlow;

    // FIX takes two cycles: sign correction, then the result write (which may also accept a start).
    assign w_can_start = (r_state == S_IDLE) || ((r_state == S_FIX) && r_fix_ph);

    always_comb begin
        w_booth_a = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_booth_a = r_a + r_m;
            2'b10:   w_booth_a = r_a - r_m;
            default: w_booth_a = r_a;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_fix_ph <= 1'b0;
            r_a      <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_zhigh  <= '0;
            r_zlow   <= '0;
`ifdef MULDIV_DIV_EN
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state  <= S_FIX;
                        r_fix_ph <= 1'b0;
                    end
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            r_a <= w_trial;
                            r_q <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_a <= w_rem_sh;
                            r_q <= {r_q[WIDTH-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        r_a  <= {w_booth_a[WIDTH], w_booth_a[WIDTH:1]};
                        r_q  <= {w_booth_a[0], r_q[WIDTH-1:1]};
                        r_q1 <= r_q[0];
                    end
                end
                S_FIX: begin
                    if (!r_fix_ph) begin
                        r_fix_ph <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (r_is_div) begin
                            if (r_dz) begin
                                r_q <= '1;
                                r_a <= {1'b0, r_dividend};
                            end else begin
                                if (r_neg_q) r_q <= -r_q;
                                if (r_neg_r) r_a <= {1'b0, -r_a[WIDTH-1:0]};
                            end
                        end
`endif
                    end else begin
                        r_zhigh <= r_a[WIDTH-1:0];
                        r_zlow  <= r_q;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef MULDIV_DIV_EN
                        r_div_zero <= r_is_div & r_dz;
`endif
                    end
                end
                default: ;
            endcase

            if (w_start && w_can_start) begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_a     <= '0;
                r_q1    <= 1'b0;
`ifdef MULDIV_DIV_EN
                r_is_div   <= !MUL;
                r_dz       <= (BUSin == '0);
                r_dividend <= RY;
                r_neg_q    <= RY[WIDTH-1] ^ BUSin[WIDTH-1];
                r_neg_r    <= RY[WIDTH-1];
                r_div_zero <= 1'b0;
                if (MUL) begin
                    r_m <= {RY[WIDTH-1], RY};
                    r_q <= BUSin;
                end else begin
                    r_m <= {1'b0, w_bus_abs};
                    r_q <= w_ry_abs;
                end
`else
                r_m <= {RY[WIDTH-1], RY};
                r_q <= BUSin;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, handshake, multiply/divide results,
// busy-time start rejection, reset behaviour; divide cases follow MULDIV_DIV_EN.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] RY = '0;
    logic [W-1:0] BUSin = '0;
    logic         MUL = 1'b0;
    logic         DIV = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] ZHIGH;
    logic [W-1:0] ZLOW;
    logic         div_zero;

    int n_total = 0;
    int n_pass  = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .clear(clear), .RY(RY), .BUSin(BUSin),
        .MUL(MUL), .DIV(DIV), .busy(busy), .done(done),
        .ZHIGH(ZHIGH), .ZLOW(ZLOW), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive a start for one edge (edge 0); returns #1 after that edge.
    task automatic launch(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        MUL = m; DIV = d; RY = a; BUSin = b;
        @(posedge clock);
        #1;
        MUL = 1'b0; DIV = 1'b0;
    endtask

    // Step edges after edge k0 until done; edge_n = edge index of done (0 = never), gaps = idle edges before it.
    task automatic wait_done(input int k0, output int edge_n, output int gaps);
        int k;
        edge_n = 0; gaps = 0; k = k0;
        while (edge_n == 0 && k < k0 + 60) begin
            @(posedge clock);
            #1;
            k++;
            if (done) edge_n = k;
            else if (!busy) gaps++;
        end
        $display("op ry=%h bus=%h -> zhigh=%h zlow=%h dz=%b done_edge=%0d", RY, BUSin, ZHIGH, ZLOW, div_zero, edge_n);
    endtask

    task automatic run_op(input string tag, input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        int e, g;
        launch(m, d, a, b);
        wait_done(0, e, g);
        check_val({tag, "_latency"}, 64'(e), 64'd34);
        check_val({tag, "_busy_gaps"}, 64'(g), 64'd0);
    endtask

    task automatic watch(input int n, output int dones, output int busys);
        dones = 0; busys = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (done) dones++;
            if (busy) busys++;
        end
    endtask

    initial begin
        int e, g, nd, nb;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_zhigh", 64'(ZHIGH), 64'd0);
        check_val("rst_zlow", 64'(ZLOW), 64'd0);
        check_val("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clock);
        clear = 1'b1;

        // 7 * -3 = -21
        run_op("mul7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check_val("mul7xm3_hi", 64'(ZHIGH), 64'hFFFF_FFFF);
        check_val("mul7xm3_lo", 64'(ZLOW), 64'hFFFF_FFEB);
        check_val("mul7xm3_busy_at_done", 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check_val("mul7xm3_done_drop", 64'(done), 64'd0);

        // (-2^31)^2 = 2^62, with 3*4 started back-to-back on edge 34
        launch(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        repeat (33) @(posedge clock);
        #1;
        MUL = 1'b1; RY = 32'd3; BUSin = 32'd4;
        @(posedge clock);
        #1;
        MUL = 1'b0;
        check_val("minsq_done", 64'(done), 64'd1);
        check_val("minsq_hi", 64'(ZHIGH), 64'h4000_0000);
        check_val("minsq_lo", 64'(ZLOW), 64'h0);
        check_val("b2b_busy", 64'(busy), 64'd1);
        $display("op ry=80000000 bus=80000000 -> zhigh=%h zlow=%h done_edge=34", ZHIGH, ZLOW);
        wait_done(34, e, g);
        check_val("b2b_latency", 64'(e), 64'd68);
        check_val("b2b_hi", 64'(ZHIGH), 64'h0);
        check_val("b2b_lo", 64'(ZLOW), 64'hC);

`ifdef MULDIV_DIV_EN
        run_op("divm17by5", 1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5);
        check_val("divm17by5_q", 64'(ZLOW), 64'hFFFF_FFFD);
        check_val("divm17by5_r", 64'(ZHIGH), 64'hFFFF_FFFE);
        check_val("divm17by5_dz", 64'(div_zero), 64'd0);

        run_op("divminbym1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_val("divminbym1_q", 64'(ZLOW), 64'h8000_0000);
        check_val("divminbym1_r", 64'(ZHIGH), 64'h0);

        run_op("div100by0", 1'b0, 1'b1, 32'd100, 32'd0);
        check_val("div100by0_q", 64'(ZLOW), 64'hFFFF_FFFF);
        check_val("div100by0_r", 64'(ZHIGH), 64'h64);
        check_val("div100by0_dz", 64'(div_zero), 64'd1);

        run_op("mul2x2", 1'b1, 1'b0, 32'd2, 32'd2);
        check_val("mul2x2_dz", 64'(div_zero), 64'd0);
        check_val("mul2x2_lo", 64'(ZLOW), 64'd4);

        run_op("muldiv_both", 1'b1, 1'b1, 32'd3, 32'd5);
        check_val("muldiv_both_lo", 64'(ZLOW), 64'd15);
`endif

        // Operand change and extra starts while busy are ignored
        launch(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (9) @(posedge clock);
        #1;
        RY = 32'd99; BUSin = 32'd0; DIV = 1'b1; MUL = 1'b1;
        @(posedge clock);
        #1;
        DIV = 1'b0; MUL = 1'b0;
        wait_done(10, e, g);
        check_val("busyign_latency", 64'(e), 64'd34);
        check_val("busyign_lo", 64'(ZLOW), 64'd30);
        check_val("busyign_hi", 64'(ZHIGH), 64'd0);

        // Reset mid-operation at edge 20
        launch(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (19) @(posedge clock);
        #1;
        clear = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_hi", 64'(ZHIGH), 64'd0);
        check_val("midrst_lo", 64'(ZLOW), 64'd0);
        check_val("midrst_dz", 64'(div_zero), 64'd0);
        $display("op reset at edge 20 -> zhigh=%h zlow=%h busy=%b", ZHIGH, ZLOW, busy);
        run_op("mul2x3", 1'b1, 1'b0, 32'd2, 32'd3);
        check_val("mul2x3_lo", 64'(ZLOW), 64'd6);
        check_val("mul2x3_hi", 64'(ZHIGH), 64'd0);

`ifndef MULDIV_DIV_EN
        // Divider absent: DIV does nothing
        launch(1'b0, 1'b1, 32'd9, 32'd3);
        watch(40, nd, nb);
        $display("op div 9/3 (disabled) -> zhigh=%h zlow=%h dones=%0d busys=%0d", ZHIGH, ZLOW, nd, nb);
        check_val("nodiv_dones", 64'(nd), 64'd0);
        check_val("nodiv_busy", 64'(nb), 64'd0);
        check_val("nodiv_lo", 64'(ZLOW), 64'd6);
        check_val("nodiv_hi", 64'(ZHIGH), 64'd0);
        check_val("nodiv_dz", 64'(div_zero), 64'd0);
`endif

        // Reset and start on the same edge: reset wins
        @(negedge clock);
        clear = 1'b0; MUL = 1'b1; RY = 32'd1; BUSin = 32'd1;
        @(posedge clock);
        #1;
        clear = 1'b1; MUL = 1'b0;
        check_val("rststart_busy", 64'(busy), 64'd0);
        watch(40, nd, nb);
        $display("op reset+start same edge -> zhigh=%h zlow=%h dones=%0d", ZHIGH, ZLOW, nd);
        check_val("rststart_dones", 64'(nd), 64'd0);
        check_val("rststart_lo", 64'(ZLOW), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle signed multiply/divide unit that sits beside the single-cycle ALU on the datapath. It takes the same operand pair: RY from the Y register and BUSin from the bus. It writes a 64-bit result into the ZHIGH/ZLOW register pair that the control unit later drives onto the bus. The control sequencer starts an operation with a one-cycle command pulse and waits for `done`. The unit is sequential: a radix-2 iterative datapath with a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand width; result is 2*WIDTH split across ZHIGH/ZLOW.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  reset; synchronous, active-low.
- `RY`  in  32  multiplicand / dividend.
- `BUSin`  in  32  multiplier / divisor.
- `MUL`  in  1  start signed multiply; sampled only when idle.
- `DIV`  in  1  start signed divide; sampled only when idle.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when ZHIGH/ZLOW update with a new result.
- `ZHIGH`  out  32  product[63:32] or remainder.
- `ZLOW`  out  32  product[31:0] or quotient.
- `div_zero`  out  1  last divide had BUSin == 0; held until the next start.

## Operation
- States:
  - IDLE.
  - RUN: 32 iterations, tracked by a 5-bit counter.
  - FIX: sign correction and result write.
- IDLE → RUN on a rising edge with MUL or DIV high.
  - RY and BUSin are captured into internal registers on that edge.
  - Later changes to RY/BUSin are ignored.
  - MUL and DIV both high: MUL wins (same priority order as the ALU chain).
- RUN → FIX after the 32nd iteration.
- FIX → IDLE: ZHIGH/ZLOW written, `done`=1 for that one cycle.
- Multiply:
  - Booth radix-2, signed two's complement.
  - Full 64-bit product, with ZHIGH:ZLOW = RY*BUSin.
- Divide:
  - Restoring on operand magnitudes, then sign fix in FIX.
  - Quotient truncates toward zero; remainder takes the sign of the dividend (RY).
  - ZLOW = quotient, ZHIGH = remainder.
  - -2^31 / -1 wraps: ZLOW=0x80000000, ZHIGH=0.
- Divide by zero:
  - Iterations still run (uniform latency).
  - FIX forces ZLOW=0xFFFFFFFF and ZHIGH=dividend, and sets `div_zero`=1.
- MUL/DIV high while `busy`=1: ignored, no queueing.
- ZHIGH/ZLOW hold the last result until the next FIX; they are not modified during RUN.

## Timing
- Start sampled at edge 0 → `busy`=1 after edge 0 through edge 33.
- Edge 34: ZHIGH/ZLOW/`div_zero` update, `done`=1 and `busy`=0 for the cycle following edge 34.
- `done` drops after edge 35.
- Fixed latency: 34 cycles, for both operations and all operand values.
- A new start is accepted on edge 34 itself (back-to-back), giving one operation per 34 cycles.
- Reset values (clear low at an edge): state IDLE, `busy`=0, `done`=0, ZHIGH=0, ZLOW=0, `div_zero`=0.
- Reset mid-operation discards the in-flight result; no `done` is produced.
- Reset and start on the same edge: reset wins; start is lost.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath and `div_zero` logic are present, as described above.
- Not defined:
  - DIV is ignored in IDLE: no busy, no done, outputs unchanged.
  - `div_zero` is tied to 0.
  - MUL+DIV together is treated as MUL.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MUL, RY=7, BUSin=0xFFFFFFFD (-3) → at edge 34 ZHIGH=0xFFFFFFFF, ZLOW=0xFFFFFFEB, `done` one cycle, `busy` high for edges 1–33 exactly.
- MUL, RY=BUSin=0x80000000 → ZHIGH=0x40000000, ZLOW=0x00000000; then immediate MUL 3×4 on edge 34 → next result ZLOW=0x0000000C, ZHIGH=0 at edge 68.
- DIV, RY=0xFFFFFFEF (-17), BUSin=5 → ZLOW=0xFFFFFFFD (-3), ZHIGH=0xFFFFFFFE (-2), `div_zero`=0.
- DIV, RY=100, BUSin=0 → ZLOW=0xFFFFFFFF, ZHIGH=0x00000064, `div_zero`=1; following MUL 2×2 → `div_zero`=0, ZLOW=4.
- MUL 5×6 started; RY changed and DIV pulsed at cycle 10 → result still ZLOW=30 at edge 34. Repeat with clear low at cycle 20 → all outputs 0, no `done`, unit accepts a new start on the next edge.
- `MULDIV_DIV_EN` undefined: DIV pulse with RY=9, BUSin=3 → `busy` stays 0, ZHIGH/ZLOW unchanged, no `done`.
